// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - shared encodings and constants for the interrupt/trap sequencer
package trap_pkg;

   typedef enum logic [2:0] {IDLE, DRAIN, LD_EPC, LD_IDR, BRANCH, ISR} state_t;

   // Source codes double as bit positions in the pending vector.
   typedef enum logic [1:0] {SRC_SOVF = 2'd0, SRC_KBD = 2'd1, SRC_TICK = 2'd2} src_t;

   localparam logic [15:0] VEC_KBD  = 16'h03FF;
   localparam logic [15:0] VEC_TICK = 16'h03FE;
   localparam logic [15:0] VEC_SOVF = 16'h03FD;

   localparam int R_EPC = 30;
   localparam int R_IDR = 28;

   function automatic src_t pick_src(input logic [2:0] pend);
      if (pend[SRC_SOVF])
         return SRC_SOVF;
      else if (pend[SRC_KBD])
         return SRC_KBD;
      else
         return SRC_TICK;
   endfunction

   function automatic logic [15:0] vector_of(input src_t s);
      case (s)
         SRC_KBD:  return VEC_KBD;
         SRC_TICK: return VEC_TICK;
         default:  return VEC_SOVF;
      endcase
   endfunction

endpackage

// File: rtl/trap_if.sv
// rtl/trap_if.sv - request inputs and fetch-control outputs of the trap sequencer
interface trap_if;
   logic        kbd_req;
   logic [7:0]  kbd_data;
   logic        tick_req;
   logic        sovf_req;
   logic [15:0] pc_curr;
   logic        stall;
   logic        reti;
   logic        keyboard_hazard;
   logic        game_tick_hazard;
   logic        stack_overflow_hazard;
   logic        ld_epc;
   logic        ld_idr;
   logic [15:0] EPC;
   logic [7:0]  idr_data;
   logic        branch_to_keyboard_ISR;
   logic        branch_to_gametick_ISR;
   logic        branch_to_stackoverflow_ISR;
   logic        in_isr;
   logic        kbd_overrun;

   modport master (
      output kbd_req, kbd_data, tick_req, sovf_req, pc_curr, stall, reti,
      input  keyboard_hazard, game_tick_hazard, stack_overflow_hazard,
             ld_epc, ld_idr, EPC, idr_data,
             branch_to_keyboard_ISR, branch_to_gametick_ISR, branch_to_stackoverflow_ISR,
             in_isr, kbd_overrun
   );

   modport slave (
      input  kbd_req, kbd_data, tick_req, sovf_req, pc_curr, stall, reti,
      output keyboard_hazard, game_tick_hazard, stack_overflow_hazard,
             ld_epc, ld_idr, EPC, idr_data,
             branch_to_keyboard_ISR, branch_to_gametick_ISR, branch_to_stackoverflow_ISR,
             in_isr, kbd_overrun
   );
endinterface

// File: rtl/trap_priority_latch.sv
// rtl/trap_priority_latch.sv - sticky pending bits, keyboard data latch, overrun flag, priority pick
module trap_priority_latch
   import trap_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       kbd_req,
   input  logic [7:0] kbd_data,
   input  logic       tick_req,
   input  logic       sovf_req,
   input  logic       clr_en,
   input  src_t       clr_src,
   output logic       any_req,
   output src_t       sel_src,
   output logic [7:0] kbd_latch,
   output logic       kbd_overrun
);

   logic [2:0] pend;
   logic [2:0] req_vec;
   logic [2:0] clr_vec;
   logic [2:0] view;

   assign req_vec = {tick_req, kbd_req, sovf_req};
   assign clr_vec = clr_en ? (3'b001 << clr_src) : 3'b000;

   // Same-cycle requests are visible so an idle sequencer accepts without a bubble.
   assign view    = pend | req_vec;
   assign any_req = |view;
   assign sel_src = pick_src(view);

   always_ff @(posedge clk) begin
      if (rst) begin
         pend        <= 3'b000;
         kbd_latch   <= 8'h00;
         kbd_overrun <= 1'b0;
      end else begin
         pend <= (pend & ~clr_vec) | req_vec;
         if (kbd_req) begin
            kbd_latch <= kbd_data;
            if (pend[SRC_KBD])
               kbd_overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/trap_handler.sv
// rtl/trap_handler.sv - drains fetch, injects EPC/keyboard loads and strobes the ISR vector select
module trap_handler
   import trap_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 2
) (
   input logic   clk,
   input logic   rst,
   trap_if.slave bus
);

   state_t           state;
   state_t           nxt;
   src_t             src;
   src_t             nsrc;
   src_t             sel_src;
   logic [CNT_W-1:0] cnt;
   logic             any_req;
   logic [7:0]       kbd_latch;
   logic             active;

   trap_priority_latch u_latch (
      .clk         (clk),
      .rst         (rst),
      .kbd_req     (bus.kbd_req),
      .kbd_data    (bus.kbd_data),
      .tick_req    (bus.tick_req),
      .sovf_req    (bus.sovf_req),
      .clr_en      (state == BRANCH && !bus.stall),
      .clr_src     (src),
      .any_req     (any_req),
      .sel_src     (sel_src),
      .kbd_latch   (kbd_latch),
      .kbd_overrun (bus.kbd_overrun)
   );

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (any_req && !bus.stall) nxt = DRAIN;
         DRAIN:   if (!bus.stall && cnt == CNT_W'(1)) nxt = LD_EPC;
         LD_EPC:  if (!bus.stall) nxt = (src == SRC_KBD) ? LD_IDR : BRANCH;
         LD_IDR:  if (!bus.stall) nxt = BRANCH;
         BRANCH:  if (!bus.stall) nxt = ISR;
         ISR:     if (bus.reti) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign nsrc   = (state == IDLE) ? sel_src : src;
   assign active = (nxt == DRAIN) || (nxt == LD_EPC) || (nxt == LD_IDR) || (nxt == BRANCH);

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                           <= IDLE;
         src                             <= SRC_SOVF;
         cnt                             <= '0;
         bus.EPC                         <= 16'h0000;
         bus.idr_data                    <= 8'h00;
         bus.keyboard_hazard             <= 1'b0;
         bus.game_tick_hazard            <= 1'b0;
         bus.stack_overflow_hazard       <= 1'b0;
         bus.ld_epc                      <= 1'b0;
         bus.ld_idr                      <= 1'b0;
         bus.branch_to_keyboard_ISR      <= 1'b0;
         bus.branch_to_gametick_ISR      <= 1'b0;
         bus.branch_to_stackoverflow_ISR <= 1'b0;
         bus.in_isr                      <= 1'b0;
      end else begin
         state <= nxt;
         src   <= nsrc;
         if (state == IDLE && nxt == DRAIN) begin
            bus.EPC <= bus.pc_curr;
            cnt     <= CNT_W'(DRAIN_CYCLES);
         end else if (state == DRAIN && !bus.stall) begin
            cnt <= cnt - 1'b1;
         end
         if (state == LD_EPC && nxt == LD_IDR)
            bus.idr_data <= kbd_latch;
         bus.keyboard_hazard             <= active && nsrc == SRC_KBD;
         bus.game_tick_hazard            <= active && nsrc == SRC_TICK;
         bus.stack_overflow_hazard       <= active && nsrc == SRC_SOVF;
         bus.ld_epc                      <= nxt == LD_EPC;
         bus.ld_idr                      <= nxt == LD_IDR;
         bus.branch_to_keyboard_ISR      <= nxt == BRANCH && nsrc == SRC_KBD;
         bus.branch_to_gametick_ISR      <= nxt == BRANCH && nsrc == SRC_TICK;
         bus.branch_to_stackoverflow_ISR <= nxt == BRANCH && nsrc == SRC_SOVF;
         bus.in_isr                      <= nxt == ISR;
      end
   end

endmodule

// File: tb/tb_trap_handler.sv
// tb/tb_trap_handler.sv - scoreboard bench for trap_handler with directed vectors
module tb_trap_handler;
   import trap_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   typedef struct {
      int          kind;
      int          at;
      logic [31:0] val;
   } ev_t;

   ev_t exp_q[$];

   trap_if bus ();

   trap_handler #(.DRAIN_CYCLES(3), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Event kinds: 0 ld_epc, 1 ld_idr, 2 sovf branch, 3 kbd branch, 4 tick branch.
   task automatic push(input int kind, input int at, input logic [31:0] val);
      ev_t e;
      e.kind = kind;
      e.at   = at;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   task automatic at_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      int   n;
      int   h;
      int   kind;
      ev_t  e;
      if (cyc >= 1) begin
         n = int'(bus.ld_epc) + int'(bus.ld_idr) + int'(bus.branch_to_keyboard_ISR)
             + int'(bus.branch_to_gametick_ISR) + int'(bus.branch_to_stackoverflow_ISR);
         h = int'(bus.keyboard_hazard) + int'(bus.game_tick_hazard) + int'(bus.stack_overflow_hazard);
         checks++;
         if (n > 1 || h > 1) begin
            failures++;
            $display("FAIL exclusive cycle %0d: strobes %0d hazards %0d, required at most 1 each", cyc, n, h);
         end
         if (n == 1) begin
            kind = bus.ld_epc ? 0 : bus.ld_idr ? 1 : bus.branch_to_stackoverflow_ISR ? 2 :
                   bus.branch_to_keyboard_ISR ? 3 : 4;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event cycle %0d: got kind %0d, expected none", cyc, kind);
            end else begin
               e = exp_q.pop_front();
               chk("event_kind", kind, e.kind);
               chk("event_cycle", cyc, e.at);
               if (kind == 0)
                  chk("EPC", 32'(bus.EPC), e.val);
               else if (kind == 1)
                  chk("idr_data", 32'(bus.idr_data), e.val);
            end
         end
      end
   end

   initial begin
      bus.kbd_req  = 1'b0;
      bus.kbd_data = 8'h00;
      bus.tick_req = 1'b0;
      bus.sovf_req = 1'b0;
      bus.pc_curr  = 16'h0000;
      bus.stall    = 1'b0;
      bus.reti     = 1'b0;

      at_cycle(1);
      @(negedge clk);
      chk("rst_kbd_hazard", bus.keyboard_hazard, 0);
      chk("rst_ld_epc", bus.ld_epc, 0);
      chk("rst_in_isr", bus.in_isr, 0);
      chk("rst_EPC", bus.EPC, 0);
      chk("rst_idr_data", bus.idr_data, 0);
      chk("rst_overrun", bus.kbd_overrun, 0);
      at_cycle(2);
      rst = 1'b0;

      // keyboard path
      at_cycle(5);
      bus.kbd_req = 1'b1; bus.kbd_data = 8'h41; bus.pc_curr = 16'h0123;
      push(0, 9, 32'h0123); push(1, 10, 32'h41); push(3, 11, 0);
      at_cycle(6);
      bus.kbd_req = 1'b0;
      @(negedge clk); chk("kbd_hazard_drain", bus.keyboard_hazard, 1);
      at_cycle(11);
      @(negedge clk); chk("kbd_hazard_branch", bus.keyboard_hazard, 1);
      at_cycle(12);
      @(negedge clk); chk("kbd_hazard_isr", bus.keyboard_hazard, 0); chk("kbd_in_isr", bus.in_isr, 1);
      at_cycle(14); bus.reti = 1'b1;
      at_cycle(15); bus.reti = 1'b0;
      @(negedge clk); chk("kbd_reti_idle", bus.in_isr, 0);

      // simultaneous tick + stack overflow
      at_cycle(17);
      bus.tick_req = 1'b1; bus.sovf_req = 1'b1; bus.pc_curr = 16'h0200;
      push(0, 21, 32'h0200); push(2, 22, 0);
      at_cycle(18);
      bus.tick_req = 1'b0; bus.sovf_req = 1'b0;
      @(negedge clk); chk("sim_sovf_hazard", bus.stack_overflow_hazard, 1); chk("sim_tick_hazard", bus.game_tick_hazard, 0);
      at_cycle(24);
      bus.pc_curr = 16'h0300;
      @(negedge clk); chk("sim_tick_waits", bus.game_tick_hazard, 0); chk("sim_in_isr", bus.in_isr, 1);
      at_cycle(25);
      bus.reti = 1'b1;
      push(0, 30, 32'h0300); push(4, 31, 0);
      at_cycle(26); bus.reti = 1'b0;
      at_cycle(27);
      @(negedge clk); chk("sim_tick_drain", bus.game_tick_hazard, 1);
      at_cycle(33); bus.reti = 1'b1;
      at_cycle(34); bus.reti = 1'b0;

      // stall while in LD_EPC
      at_cycle(36);
      bus.tick_req = 1'b1; bus.pc_curr = 16'h0400;
      push(0, 40, 32'h0400); push(0, 41, 32'h0400); push(0, 42, 32'h0400); push(4, 43, 0);
      at_cycle(37); bus.tick_req = 1'b0;
      at_cycle(40); bus.stall = 1'b1;
      at_cycle(42); bus.stall = 1'b0;
      at_cycle(45); bus.reti = 1'b1;
      at_cycle(46); bus.reti = 1'b0;

      // keyboard overrun
      at_cycle(48);
      bus.kbd_req = 1'b1; bus.kbd_data = 8'h10; bus.pc_curr = 16'h0500;
      push(0, 52, 32'h0500); push(1, 53, 32'h20); push(3, 54, 0);
      at_cycle(49);
      bus.kbd_req = 1'b0;
      @(negedge clk); chk("ovr_before", bus.kbd_overrun, 0);
      at_cycle(50); bus.kbd_req = 1'b1; bus.kbd_data = 8'h20;
      at_cycle(51); bus.kbd_req = 1'b0;
      @(negedge clk); chk("ovr_set", bus.kbd_overrun, 1);

      // tick arriving during the ISR
      at_cycle(56); bus.tick_req = 1'b1;
      at_cycle(57); bus.tick_req = 1'b0;
      at_cycle(58);
      bus.pc_curr = 16'h0600;
      @(negedge clk); chk("nest_no_hazard", bus.game_tick_hazard, 0); chk("nest_in_isr", bus.in_isr, 1);
      at_cycle(60);
      bus.reti = 1'b1;
      push(0, 65, 32'h0600); push(4, 66, 0);
      at_cycle(61);
      bus.reti = 1'b0;
      @(negedge clk); chk("nest_idle_gap", bus.game_tick_hazard, 0); chk("nest_idle_isr", bus.in_isr, 0);
      at_cycle(62);
      @(negedge clk); chk("nest_drain", bus.game_tick_hazard, 1);
      at_cycle(68); bus.reti = 1'b1;
      at_cycle(69);
      bus.reti = 1'b0;
      @(negedge clk); chk("ovr_sticky", bus.kbd_overrun, 1);

      // reset during DRAIN
      at_cycle(71);
      bus.kbd_req = 1'b1; bus.kbd_data = 8'h55; bus.pc_curr = 16'h0700;
      at_cycle(72);
      bus.kbd_req = 1'b0;
      @(negedge clk); chk("rst_mid_drain", bus.keyboard_hazard, 1);
      at_cycle(73); rst = 1'b1;
      at_cycle(74);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_hazard", bus.keyboard_hazard, 0);
      chk("rst_mid_overrun", bus.kbd_overrun, 0);
      chk("rst_mid_EPC", bus.EPC, 0);
      chk("rst_mid_idr", bus.idr_data, 0);
      at_cycle(80);
      @(negedge clk);
      chk("rst_pending_hazard", bus.keyboard_hazard, 0);
      chk("rst_pending_isr", bus.in_isr, 0);

      at_cycle(92);
      chk("events_outstanding", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
